// File: rtl/frame_writer_if.sv
// Command/status and frame-buffer write port bundle for frame_writer.
// The master side is software (or a bench); the slave side is the writer.
interface frame_writer_if #(
    parameter int ADDR_W = 19
);
    logic [1:0]        to_hw_sig;
    logic [31:0]       cmd_pos;
    logic [31:0]       cmd_size;
    logic [7:0]        cmd_color;
    logic [1:0]        to_sw_sig;
    logic [ADDR_W-1:0] frame_wrAddress;
    logic [7:0]        frame_input;
    logic              frame_we;

    modport master (
        output to_hw_sig, cmd_pos, cmd_size, cmd_color,
        input  to_sw_sig, frame_wrAddress, frame_input, frame_we
    );

    modport slave (
        input  to_hw_sig, cmd_pos, cmd_size, cmd_color,
        output to_sw_sig, frame_wrAddress, frame_input, frame_we
    );
endinterface

// File: rtl/frame_writer.sv
// Rectangle-fill / clear-screen engine writing one pixel per clock into a
// linear frame buffer, with a four-phase command/status handshake.
module frame_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic          Clk,
    input  logic          reset_n,
    frame_writer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [1:0]  SW_IDLE   = 2'b00;
    localparam logic [1:0]  SW_BUSY   = 2'b01;
    localparam logic [1:0]  SW_DONE   = 2'b10;
    localparam logic [1:0]  CMD_NONE  = 2'b00;
    localparam logic [1:0]  CMD_FILL  = 2'b01;
    localparam logic [1:0]  CMD_CLEAR = 2'b10;
    localparam logic [10:0] H_RES11   = 11'(H_RES);
    localparam logic [10:0] V_RES11   = 11'(V_RES);
    localparam logic [31:0] H_RES_BITS = 32'(H_RES);

    state_t            state;
    logic              clear_q;
    logic              last_q;
    logic [9:0]        x_cnt;
    logic [9:0]        y_cnt;
    logic [9:0]        w_eff;
    logic [9:0]        h_eff;
    logic [7:0]        color;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_step;

    // Constant multiply by H_RES unrolled into a shift-add tree.
    function automatic logic [ADDR_W-1:0] row_base(input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (H_RES_BITS[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    logic [9:0]        s_x0;
    logic [9:0]        s_y0;
    logic [9:0]        s_w;
    logic [9:0]        s_h;
    logic [10:0]       avail_w;
    logic [10:0]       avail_h;
    logic [9:0]        s_w_eff;
    logic [9:0]        s_h_eff;
    logic              s_empty;
    logic [ADDR_W-1:0] s_base;
    logic [ADDR_W-1:0] s_row_step;

    // Clipping of the live command, consumed only while in SETUP.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        s_x0 = bus.cmd_pos[9:0];
        s_y0 = bus.cmd_pos[25:16];
        s_w  = bus.cmd_size[9:0];
        s_h  = bus.cmd_size[25:16];
        if (clear_q) begin
            s_x0 = '0;
            s_y0 = '0;
            s_w  = 10'(H_RES);
            s_h  = 10'(V_RES);
        end
        avail_w    = H_RES11 - {1'b0, s_x0};
        avail_h    = V_RES11 - {1'b0, s_y0};
        s_empty    = ({1'b0, s_x0} >= H_RES11) || ({1'b0, s_y0} >= V_RES11) ||
                     (s_w == '0) || (s_h == '0);
        s_w_eff    = ({1'b0, s_w} < avail_w) ? s_w : avail_w[9:0];
        s_h_eff    = ({1'b0, s_h} < avail_h) ? s_h : avail_h[9:0];
        s_base     = row_base(s_y0) + ADDR_W'(s_x0);
        s_row_step = ADDR_W'(H_RES) - ADDR_W'(s_w_eff) + ADDR_W'(1);
    end

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{bus.cmd_pos[31:26], bus.cmd_pos[15:10],
                               bus.cmd_size[31:26], bus.cmd_size[15:10]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            clear_q             <= 1'b0;
            last_q              <= 1'b0;
            x_cnt               <= '0;
            y_cnt               <= '0;
            w_eff               <= '0;
            h_eff               <= '0;
            color               <= '0;
            addr                <= '0;
            row_step            <= '0;
            bus.to_sw_sig       <= SW_IDLE;
            bus.frame_wrAddress <= '0;
            bus.frame_input     <= '0;
            bus.frame_we        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.frame_we <= 1'b0;
                    if (bus.to_hw_sig == CMD_FILL || bus.to_hw_sig == CMD_CLEAR) begin
                        clear_q       <= (bus.to_hw_sig == CMD_CLEAR);
                        state         <= SETUP;
                        bus.to_sw_sig <= SW_BUSY;
                    end
                end

                SETUP: begin
                    w_eff    <= s_w_eff;
                    h_eff    <= s_h_eff;
                    color    <= bus.cmd_color;
                    addr     <= s_base;
                    row_step <= s_row_step;
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    last_q   <= 1'b0;
                    if (s_empty) begin
                        state         <= DONE;
                        bus.to_sw_sig <= SW_DONE;
                    end else begin
                        state <= FILL;
                    end
                end

                FILL: begin
                    if (last_q) begin
                        // Last pixel went out on the previous edge.
                        bus.frame_we  <= 1'b0;
                        last_q        <= 1'b0;
                        state         <= DONE;
                        bus.to_sw_sig <= SW_DONE;
                    end else begin
                        bus.frame_we        <= 1'b1;
                        bus.frame_wrAddress <= addr;
                        bus.frame_input     <= color;
                        if (x_cnt == w_eff - 10'd1) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 10'd1;
                            addr  <= addr + row_step;
                            if (y_cnt == h_eff - 10'd1) last_q <= 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 10'd1;
                            addr  <= addr + ADDR_W'(1);
                        end
                    end
                end

                DONE: begin
                    bus.frame_we <= 1'b0;
                    if (bus.to_hw_sig == CMD_NONE) begin
                        state         <= IDLE;
                        bus.to_sw_sig <= SW_IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.frame_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
